cpu_run_sequencer: RTL and testbench
====================================

// Module: cpu_run_sequencer
// PURPOSE
//  Top-level sequencer for the pipelined cpu. On start it streams a program into
//  instruction memory through the cpu external port, then holds cpu enable high
//  for a set number of cycles. It then reads a window of data memory back out
//  through a valid/ready stream. It sits between the test/host interface and the
//  cpu ext ports.
// PARAMETERS
//  IMEM_ADDR_W  9   instruction memory word-index width
//  DMEM_ADDR_W  10  data memory word-index width
//  DATA_W       32  word width
//  CYC_W        16  run-cycle counter width
// PORTS
//  clk            in   1              clock, rising edge
//  arst_n         in   1              asynchronous active-low reset
//  start          in   1              pulse: latch config, begin sequence (ignored when busy)
//  abort          in   1              pulse: return to IDLE immediately, no done
//  prog_len       in   IMEM_ADDR_W+1  number of program words to load
//  run_cycles     in   CYC_W          cycles to hold cpu_enable high
//  dump_base      in   DMEM_ADDR_W    first data-memory word index to read back
//  dump_len       in   DMEM_ADDR_W+1  number of data words to read back
//  in_valid       in   1              program word valid
//  in_data        in   DATA_W         program word
//  in_ready       out  1              program word accepted when in_valid&in_ready
//  out_valid      out  1              dump word valid
//  out_data       out  DATA_W         dump word
//  out_ready      in   1              dump word consumed when out_valid&out_ready
//  cpu_enable     out  1              drives cpu enable
//  imem_addr_ext  out  32             byte address (word index*4, zero-extended)
//  imem_wen_ext   out  1              imem external write enable
//  imem_ren_ext   out  1              tied 0
//  imem_wdata_ext out  DATA_W         imem external write data
//  dmem_addr_ext  out  32             byte address (word index*4, zero-extended)
//  dmem_wen_ext   out  1              tied 0
//  dmem_ren_ext   out  1              dmem external read enable
//  dmem_rdata_ext in   DATA_W         dmem read data, valid 1 cycle after ren
//  busy           out  1              state != IDLE
//  done           out  1              1-cycle pulse on normal completion
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, all counters 0, config regs 0.
//  All outputs are registered.
//  FSM: IDLE -> LOAD -> RUN -> RD -> WAIT -> OUT -> (RD | FIN) -> IDLE.
//  IDLE: on start, latch all config ports.
//   prog_len saturates at 2^IMEM_ADDR_W.
//   Phases with length 0 are skipped: LOAD if prog_len=0, RUN if run_cycles=0,
//   dump phases if dump_len=0.
//  LOAD: in_ready=1.
//   Each handshake k (k=0..prog_len-1) produces, the next cycle, imem_wen_ext=1
//   for one cycle, with addr=k*4 and wdata=in_data.
//   in_ready drops the cycle after the last handshake.
//   The FSM enters RUN after the last write has issued.
//  RUN: cpu_enable=1 for exactly run_cycles consecutive cycles, then 0.
//  RD: dmem_ren_ext=1 for 1 cycle, addr=((dump_base+i) mod 2^DMEM_ADDR_W)*4.
//  WAIT: capture dmem_rdata_ext into out_data.
//  OUT: out_valid=1; out_data is held stable until out_ready.
//   After the handshake: i++; go to RD if i<dump_len, else FIN.
//   Minimum rate is 3 cycles per word.
//  FIN: done=1 for 1 cycle, then IDLE.
//  abort (any state): next cycle state=IDLE, done=0, and every strobe/valid/enable
//   is 0. abort has priority over start in the same cycle.
//  start while busy is ignored. Config ports are don't-care after latching.
//  arst_n low mid-sequence: every output is 0 asynchronously and the FSM restarts
//   from IDLE.
//  Never active: dmem_wen_ext, imem_ren_ext. cpu_enable is 0 outside RUN.
// TESTING
//  1. prog_len=3, words A,B,C, in_valid held 1:
//     -> imem writes at addr 0,4,8 on consecutive cycles; in_ready high 3 cycles.
//  2. run_cycles=5 -> cpu_enable high exactly 5 cycles, starting the cycle after
//     the last imem write.
//  3. dump_base=1022, dump_len=4, out_ready=1:
//     -> dmem reads at 4088,4092,0,4; 4 out words; then done pulse.
//  4. dump_len=2, out_ready low 10 cycles on word 0:
//     -> out_data stable, out_valid held, no further ren; then 2 words in order.
//  5. abort during RUN cycle 2 of 5 -> cpu_enable 0 next cycle, busy 0, no done.
//  6. prog_len=0, run_cycles=0, dump_len=0:
//     -> done pulse 2 cycles after start, no strobes.

Source files
------------

// File: rtl/cpu_run_sequencer.sv
// cpu_run_sequencer: streams a program into imem, runs the cpu for a set
// number of cycles, then streams a window of dmem back out.
// Ports:
//   clk, arst_n            clock, async active-low reset
//   start, abort           sequence control pulses
//   prog_len, run_cycles   config, latched on start
//   dump_base, dump_len    dump window, latched on start
//   in_valid/ready/data    program word stream in
//   out_valid/ready/data   dump word stream out
//   cpu_enable             cpu run enable
//   imem_*_ext, dmem_*_ext cpu external memory ports (byte addresses)
//   busy, done             status; done is a 1-cycle completion pulse
module cpu_run_sequencer #(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10,
  parameter int DATA_W      = 32,
  parameter int CYC_W       = 16
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [IMEM_ADDR_W:0]   prog_len,
  input  logic [CYC_W-1:0]       run_cycles,
  input  logic [DMEM_ADDR_W-1:0] dump_base,
  input  logic [DMEM_ADDR_W:0]   dump_len,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic                   cpu_enable,
  output logic [31:0]            imem_addr_ext,
  output logic                   imem_wen_ext,
  output logic                   imem_ren_ext,
  output logic [DATA_W-1:0]      imem_wdata_ext,
  output logic [31:0]            dmem_addr_ext,
  output logic                   dmem_wen_ext,
  output logic                   dmem_ren_ext,
  input  logic [DATA_W-1:0]      dmem_rdata_ext,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LDWR,
    S_RUN,
    S_RD,
    S_WAIT,
    S_OUT,
    S_FIN
  } state_t;

  localparam logic [IMEM_ADDR_W:0] PLEN_MAX =
    {1'b1, {IMEM_ADDR_W{1'b0}}};

  state_t                 state;
  logic [IMEM_ADDR_W:0]   plen_r;
  logic [CYC_W-1:0]       run_r;
  logic [DMEM_ADDR_W-1:0] base_r;
  logic [DMEM_ADDR_W:0]   dlen_r;
  logic [IMEM_ADDR_W:0]   wcnt;
  logic [CYC_W-1:0]       rcnt;
  logic [DMEM_ADDR_W:0]   idx;

  logic [IMEM_ADDR_W:0]   plen_sat;
  logic [CYC_W-1:0]       c_run;
  logic [DMEM_ADDR_W-1:0] c_base;
  logic [DMEM_ADDR_W:0]   c_dlen;
  logic [DMEM_ADDR_W:0]   rd_idx;
  logic [DMEM_ADDR_W-1:0] rd_word;
  logic                   take;
  logic                   has_load;
  logic                   has_run;
  logic                   has_rd;
  state_t                 nxt;

  assign imem_ren_ext = 1'b0;
  assign dmem_wen_ext = 1'b0;

  assign plen_sat = (prog_len > PLEN_MAX) ? PLEN_MAX : prog_len;

  // In IDLE the phase choice must come straight from the ports,
  // since the config registers only load on the start edge.
  assign c_run  = (state == S_IDLE) ? run_cycles : run_r;
  assign c_base = (state == S_IDLE) ? dump_base  : base_r;
  assign c_dlen = (state == S_IDLE) ? dump_len   : dlen_r;

  assign rd_word = c_base + rd_idx[DMEM_ADDR_W-1:0];

  // take: current phase is finished; nxt: first non-empty phase after it
  always_comb begin
    take   = 1'b0;
    rd_idx = '0;
    unique case (state)
      S_IDLE: take = start;
      S_LDWR: take = 1'b1;
      S_RUN:  take = (rcnt == run_r);
      S_OUT: begin
        take   = out_valid & out_ready;
        rd_idx = idx + 1'b1;
      end
      default: take = 1'b0;
    endcase
    has_load = (state == S_IDLE) && (plen_sat != '0);
    has_run  = ((state == S_IDLE) || (state == S_LDWR)) &&
               (c_run != '0);
    has_rd   = rd_idx < c_dlen;
    nxt = has_load ? S_LOAD :
          has_run  ? S_RUN  :
          has_rd   ? S_RD   : S_FIN;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state          <= S_IDLE;
      plen_r         <= '0;
      run_r          <= '0;
      base_r         <= '0;
      dlen_r         <= '0;
      wcnt           <= '0;
      rcnt           <= '0;
      idx            <= '0;
      in_ready       <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      cpu_enable     <= 1'b0;
      imem_addr_ext  <= '0;
      imem_wen_ext   <= 1'b0;
      imem_wdata_ext <= '0;
      dmem_addr_ext  <= '0;
      dmem_ren_ext   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      imem_wen_ext <= 1'b0;
      dmem_ren_ext <= 1'b0;
      cpu_enable   <= 1'b0;
      done         <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            plen_r <= plen_sat;
            run_r  <= run_cycles;
            base_r <= dump_base;
            dlen_r <= dump_len;
            busy   <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_valid && in_ready) begin
            imem_wen_ext   <= 1'b1;
            imem_wdata_ext <= in_data;
            imem_addr_ext  <= {{(30-IMEM_ADDR_W){1'b0}},
                               wcnt[IMEM_ADDR_W-1:0], 2'b00};
            wcnt <= wcnt + 1'b1;
            // LDWR covers the cycle the last write is on the port
            if (wcnt == plen_r - 1'b1) begin
              in_ready <= 1'b0;
              state    <= S_LDWR;
            end
          end
        end
        S_RUN: begin
          if (!take) begin
            cpu_enable <= 1'b1;
            rcnt       <= rcnt + 1'b1;
          end
        end
        S_RD: state <= S_WAIT;
        S_WAIT: begin
          out_data  <= dmem_rdata_ext;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (take) out_valid <= 1'b0;
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (take) begin
        state <= nxt;
        unique case (nxt)
          S_LOAD: begin
            in_ready <= 1'b1;
            wcnt     <= '0;
          end
          S_RUN: begin
            cpu_enable <= 1'b1;
            rcnt       <= {{(CYC_W-1){1'b0}}, 1'b1};
          end
          S_RD: begin
            dmem_ren_ext  <= 1'b1;
            dmem_addr_ext <= {{(30-DMEM_ADDR_W){1'b0}},
                              rd_word, 2'b00};
            idx           <= rd_idx;
          end
          default: ;
        endcase
      end
      if (abort) begin
        state        <= S_IDLE;
        in_ready     <= 1'b0;
        out_valid    <= 1'b0;
        cpu_enable   <= 1'b0;
        imem_wen_ext <= 1'b0;
        dmem_ren_ext <= 1'b0;
        busy         <= 1'b0;
        done         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// tb_cpu_run_sequencer: randomized and directed sequences against a
// transaction-level model of the load / run / dump flow.
module tb_cpu_run_sequencer;

  logic        clk;
  logic        arst_n;
  logic        start;
  logic        abort;
  logic [9:0]  prog_len;
  logic [15:0] run_cycles;
  logic [9:0]  dump_base;
  logic [10:0] dump_len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        cpu_enable;
  logic [31:0] imem_addr_ext;
  logic        imem_wen_ext;
  logic        imem_ren_ext;
  logic [31:0] imem_wdata_ext;
  logic [31:0] dmem_addr_ext;
  logic        dmem_wen_ext;
  logic        dmem_ren_ext;
  logic [31:0] dmem_rdata_ext;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_err = 0;

  cpu_run_sequencer dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .start          (start),
    .abort          (abort),
    .prog_len       (prog_len),
    .run_cycles     (run_cycles),
    .dump_base      (dump_base),
    .dump_len       (dump_len),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .cpu_enable     (cpu_enable),
    .imem_addr_ext  (imem_addr_ext),
    .imem_wen_ext   (imem_wen_ext),
    .imem_ren_ext   (imem_ren_ext),
    .imem_wdata_ext (imem_wdata_ext),
    .dmem_addr_ext  (dmem_addr_ext),
    .dmem_wen_ext   (dmem_wen_ext),
    .dmem_ren_ext   (dmem_ren_ext),
    .dmem_rdata_ext (dmem_rdata_ext),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  // data memory: word appears one cycle after ren, garbage otherwise
  always @(posedge clk) begin
    if (dmem_ren_ext) dmem_rdata_ext <= memf(dmem_addr_ext);
    else dmem_rdata_ext <= $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // vm: 0 in_valid held, 1 random
  // rm: 0 out_ready held, 1 random, 2 low for first 10 valid cycles
  task automatic run_tx(input int plen, input int run, input int base,
                        input int dlen, input int vm, input int rm);
    logic [31:0] wq[$];
    logic [31:0] held_d;
    int exp_w, n, nwr, nen, nrd, nout, nrdy, nvc;
    int last_wr, first_en, done_n;
    bit pend_wr, prev_en, hold, fin;
    exp_w = (plen > 512) ? 512 : plen;
    nwr = 0; nen = 0; nrd = 0; nout = 0; nrdy = 0; nvc = 0;
    last_wr = 0; first_en = 0; done_n = 0;
    pend_wr = 0; prev_en = 0; hold = 0; fin = 0;
    held_d = '0;
    start      = 1'b1;
    prog_len   = 10'(plen);
    run_cycles = 16'(run);
    dump_base  = 10'(base);
    dump_len   = 11'(dlen);
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    @(negedge clk);
    start      = 1'b0;
    prog_len   = 10'($urandom);
    run_cycles = 16'($urandom);
    dump_base  = 10'($urandom);
    dump_len   = 11'($urandom);
    n = 1;
    while (!fin && n < 5000) begin
      if (n == 1) chk("busy_on", busy, 1);
      if (pend_wr || imem_wen_ext)
        chk("wr_strobe", imem_wen_ext, pend_wr);
      if (imem_wen_ext && pend_wr) begin
        chk("wr_addr", imem_addr_ext, nwr * 4);
        chk("wr_data", imem_wdata_ext, wq[nwr]);
        nwr++;
        last_wr = n;
      end
      if (in_ready) nrdy++;
      if (cpu_enable) begin
        if (nen == 0) first_en = n;
        else chk("en_contig", prev_en, 1);
        nen++;
      end
      prev_en = cpu_enable;
      if (dmem_ren_ext) begin
        chk("rd_addr", dmem_addr_ext, ((base + nrd) % 1024) * 4);
        chk("rd_quiet", out_valid, 0);
        nrd++;
      end
      if (hold) begin
        chk("out_hold_v", out_valid, 1);
        chk("out_hold_d", out_data, held_d);
      end
      if (dmem_wen_ext || imem_ren_ext)
        chk("tied0", {dmem_wen_ext, imem_ren_ext}, 0);
      if (out_valid) nvc++;
      if (done) begin
        chk("done_busy", busy, 0);
        done_n = n;
        fin = 1;
      end
      if (!fin) begin
        in_valid = (vm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        in_data  = $urandom;
        pend_wr  = in_valid && in_ready;
        if (pend_wr) wq.push_back(in_data);
        out_ready = (rm == 0) ? 1'b1 :
                    (rm == 1) ? 1'($urandom_range(0, 1)) :
                    (nvc > 10);
        if (out_valid && out_ready) begin
          chk("out_data", out_data,
              memf(((base + nout) % 1024) * 4));
          nout++;
          hold = 0;
        end else begin
          hold   = out_valid;
          held_d = out_data;
        end
        @(negedge clk);
        n++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("timeout", fin, 1);
    chk("n_hs", wq.size(), exp_w);
    chk("n_writes", nwr, exp_w);
    chk("n_en", nen, run);
    if (exp_w > 0 && run > 0) chk("en_start", first_en, last_wr + 1);
    if (exp_w == 0 && run > 0) chk("en_start0", first_en, 1);
    chk("n_reads", nrd, dlen);
    chk("n_outs", nout, dlen);
    if (vm == 0) chk("in_ready_cyc", nrdy, exp_w);
    if (exp_w == 0 && run == 0 && dlen == 0) chk("done_lat", done_n, 2);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    arst_n    = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    prog_len  = '0;
    run_cycles = '0;
    dump_base = '0;
    dump_len  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk("rst_ctl", {in_ready, out_valid, cpu_enable, imem_wen_ext,
                    imem_ren_ext, dmem_wen_ext, dmem_ren_ext,
                    busy, done}, 0);
    chk("rst_data", {out_data, imem_wdata_ext}, 0);
    chk("rst_addr", {imem_addr_ext, dmem_addr_ext}, 0);

    run_tx(3, 5, 0, 1, 0, 0);
    run_tx(1, 1, 1022, 4, 0, 0);
    run_tx(2, 3, 100, 2, 1, 2);
    run_tx(0, 0, 0, 0, 0, 0);
    run_tx(700, 1, 5, 1, 0, 0);

    // abort in the second enabled cycle of a 5-cycle run
    start = 1'b1; prog_len = 10'd0; run_cycles = 16'd5;
    dump_base = 10'd0; dump_len = 11'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ab_en2", cpu_enable, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_en_off", cpu_enable, 0);
    chk("ab_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      chk("ab_quiet", {done, cpu_enable, dmem_ren_ext, out_valid}, 0);
      @(negedge clk);
    end

    // abort beats start in the same cycle
    start = 1'b1; abort = 1'b1; run_cycles = 16'd4;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("ab_pri", {busy, cpu_enable}, 0);

    // reset mid-load
    start = 1'b1; prog_len = 10'd50; run_cycles = 16'd3;
    dump_len = 11'd1; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_ctl", {in_ready, out_valid, cpu_enable, imem_wen_ext,
                     dmem_ren_ext, busy, done}, 0);
    chk("arst_addr", {imem_addr_ext, dmem_addr_ext}, 0);
    @(negedge clk);
    arst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("arst_idle", {busy, in_ready}, 0);

    for (int t = 0; t < 25; t++) begin
      run_tx($urandom_range(0, 40), $urandom_range(0, 30),
             $urandom_range(0, 1023), $urandom_range(0, 12),
             $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
